sc_spi_tgt: RTL

SPI target (slave) protocol engine: the far end of the SPI master engine on the same bus. It oversamples an external SPI master's CSB/SCLK/MOSI on the system clock and supports all four CPOL/CPHA modes and both byte orders. It deserializes MOSI into 32-bit words for the host-side buffer and serializes 32-bit transmit words from that buffer onto MISO. It sits between the board-level SPI pins and the target register/buffer block.

---
 rtl/sc_spi_tgt.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sc_spi_tgt.sv
`default_nettype none
// ============================================================================
//  Module   : sc_spi_tgt
//  Purpose  : SPI target protocol engine. Oversamples CSB/SCLK/MOSI on the
//             system clock, supports CPOL/CPHA modes 0..3 and MSB-first or
//             byte-0-first word order, deserializes MOSI into 32-bit words
//             and serializes 32-bit transmit words onto MISO.
//  Revision : 1.0  initial release
// ============================================================================
module sc_spi_tgt (
  input  logic        SYSCLK,
  input  logic        SYSRST,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        BORDER,
  input  logic        SCSB,
  input  logic        SSCLK,
  input  logic        SMOSI,
  output logic        SMISO,
  output logic        SMISOEN,
  input  logic [31:0] TXDATA,
  output logic [3:0]  TXDPT,
  output logic [31:0] RXDATA,
  output logic        RXVALID,
  output logic [3:0]  RXDPT,
  output logic [5:0]  RXBITS,
  output logic        BUSY,
  output logic        FRMEND
);

  typedef enum logic [1:0] {
    ST_WAITHI = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [5:0] C_FULL_WORD = 6'd32;

  // Wire-order bit n (0 = first on the wire) to register bit position.
  // MSB-first: 31-n. Byte-0-first: byte n/8, bit 7-(n%8) within the byte.
  function automatic logic [4:0] bit_pos(input logic border, input logic [4:0] idx);
    bit_pos = border ? {idx[4:3], ~idx[2:0]} : ~idx;
  endfunction

  // Synchronizer and history flops
  logic       csb_s1_q, csb_s2_q, csb_h_q;
  logic       sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [1:0] prime_q;

  // Protocol state
  state_t      state_q,   state_d;
  logic [8:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] rx_sh_q,   rx_sh_d;
  logic [31:0] tx_sh_q,   tx_sh_d;
  logic [4:0]  tx_idx_q,  tx_idx_d;
  logic        tx_run_q,  tx_run_d;
  logic        smiso_q,   smiso_d;
  logic        busy_q,    busy_d;
  logic [3:0]  txdpt_q,   txdpt_d;
  logic [31:0] rxdata_q,  rxdata_d;
  logic        rxvalid_q, rxvalid_d;
  logic [3:0]  rxdpt_q,   rxdpt_d;
  logic [5:0]  rxbits_q,  rxbits_d;
  logic        frmend_q,  frmend_d;

  // Edge decode
  logic        w_sclk_rise, w_sclk_fall;
  logic        w_lead, w_trail, w_sample, w_shift;
  logic        w_csb_fall, w_csb_rise;
  logic [4:0]  w_rx_pos, w_tx_pos_next, w_pos0;
  logic [31:0] w_rx_next;

  // Two-flop synchronizers plus one history flop per edge-detected input.
  // prime_q marks when the CSB chain holds a genuinely sampled pin value,
  // so the reset value of the chain is never mistaken for an idle-high CSB.
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      csb_s1_q  <= 1'b1;
      csb_s2_q  <= 1'b1;
      csb_h_q   <= 1'b1;
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_h_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      prime_q   <= 2'b00;
    end else begin
      csb_s1_q  <= SCSB;
      csb_s2_q  <= csb_s1_q;
      csb_h_q   <= csb_s2_q;
      sclk_s1_q <= SSCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      mosi_s1_q <= SMOSI;
      mosi_s2_q <= mosi_s1_q;
      prime_q   <= {prime_q[0], 1'b1};
    end
  end

  // Edge classification from mode pins
  always_comb begin
    w_sclk_rise   = sclk_s2_q & ~sclk_h_q;
    w_sclk_fall   = ~sclk_s2_q & sclk_h_q;
    w_lead        = CPOL ? w_sclk_fall : w_sclk_rise;
    w_trail       = CPOL ? w_sclk_rise : w_sclk_fall;
    w_sample      = CPHA ? w_trail : w_lead;
    w_shift       = CPHA ? w_lead : w_trail;
    w_csb_fall    = ~csb_s2_q & csb_h_q;
    w_csb_rise    = csb_s2_q & ~csb_h_q;
    w_rx_pos      = bit_pos(BORDER, bit_cnt_q[4:0]);
    w_tx_pos_next = bit_pos(BORDER, tx_idx_q + 5'd1);
    w_pos0        = bit_pos(BORDER, 5'd0);
    w_rx_next     = rx_sh_q;
    w_rx_next[w_rx_pos] = mosi_s2_q;
  end

  // Frame state machine, RX deserializer and TX serializer next-state logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    tx_idx_d  = tx_idx_q;
    tx_run_d  = tx_run_q;
    smiso_d   = smiso_q;
    busy_d    = busy_q;
    txdpt_d   = txdpt_q;
    rxdata_d  = rxdata_q;
    rxvalid_d = 1'b0;
    rxdpt_d   = rxdpt_q;
    rxbits_d  = rxbits_q;
    frmend_d  = 1'b0;

    case (state_q)
      ST_WAITHI: begin
        // A CSB held low across reset must first go high before a frame
        if (prime_q[1] && csb_s2_q) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (w_csb_fall) begin
          state_d   = ST_ACTIVE;
          busy_d    = 1'b1;
          bit_cnt_d = 9'd0;
          rx_sh_d   = 32'd0;
          tx_sh_d   = TXDATA;
          tx_idx_d  = 5'd0;
          txdpt_d   = 4'd1;
          if (!CPHA) begin
            // Mode with sample on leading edge: bit 0 must be on the pin now
            smiso_d  = TXDATA[w_pos0];
            tx_run_d = 1'b1;
          end else begin
            // First leading edge will present bit 0
            smiso_d  = 1'b0;
            tx_run_d = 1'b0;
          end
        end
      end

      ST_ACTIVE: begin
        if (w_csb_rise) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          smiso_d  = 1'b0;
          txdpt_d  = 4'd0;
          frmend_d = 1'b1;
          if (bit_cnt_q[4:0] != 5'd0) begin
            // Partial trailing word: unreceived positions are already zero
            rxvalid_d = 1'b1;
            rxdata_d  = rx_sh_q;
            rxbits_d  = {1'b0, bit_cnt_q[4:0]};
            rxdpt_d   = bit_cnt_q[8:5];
          end
        end else begin
          if (w_sample) begin
            bit_cnt_d = bit_cnt_q + 9'd1;
            if (bit_cnt_q[4:0] == 5'd31) begin
              rxvalid_d = 1'b1;
              rxdata_d  = w_rx_next;
              rxbits_d  = C_FULL_WORD;
              rxdpt_d   = bit_cnt_q[8:5];
              rx_sh_d   = 32'd0;
            end else begin
              rx_sh_d   = w_rx_next;
            end
          end
          if (w_shift) begin
            if (!tx_run_q) begin
              tx_run_d = 1'b1;
              smiso_d  = tx_sh_q[w_pos0];
            end else if (tx_idx_q == 5'd31) begin
              // Word boundary: fetch the word TXDPT has been pointing at
              tx_idx_d = 5'd0;
              tx_sh_d  = TXDATA;
              txdpt_d  = txdpt_q + 4'd1;
              smiso_d  = TXDATA[w_pos0];
            end else begin
              tx_idx_d = tx_idx_q + 5'd1;
              smiso_d  = tx_sh_q[w_tx_pos_next];
            end
          end
        end
      end

      default: begin
        state_d = ST_WAITHI;
      end
    endcase
  end

  // Protocol state registers
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      state_q   <= ST_WAITHI;
      bit_cnt_q <= 9'd0;
      rx_sh_q   <= 32'd0;
      tx_sh_q   <= 32'd0;
      tx_idx_q  <= 5'd0;
      tx_run_q  <= 1'b0;
      smiso_q   <= 1'b0;
      busy_q    <= 1'b0;
      txdpt_q   <= 4'd0;
      rxdata_q  <= 32'd0;
      rxvalid_q <= 1'b0;
      rxdpt_q   <= 4'd0;
      rxbits_q  <= 6'd0;
      frmend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      tx_idx_q  <= tx_idx_d;
      tx_run_q  <= tx_run_d;
      smiso_q   <= smiso_d;
      busy_q    <= busy_d;
      txdpt_q   <= txdpt_d;
      rxdata_q  <= rxdata_d;
      rxvalid_q <= rxvalid_d;
      rxdpt_q   <= rxdpt_d;
      rxbits_q  <= rxbits_d;
      frmend_q  <= frmend_d;
    end
  end

  assign SMISO   = smiso_q;
  assign SMISOEN = busy_q;
  assign BUSY    = busy_q;
  assign TXDPT   = txdpt_q;
  assign RXDATA  = rxdata_q;
  assign RXVALID = rxvalid_q;
  assign RXDPT   = rxdpt_q;
  assign RXBITS  = rxbits_q;
  assign FRMEND  = frmend_q;

endmodule
`default_nettype wire
